mem_wb_pipe_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_payload_reg.sv | 27 ++
 rtl/mem_wb_pipe_reg.sv | 131 +++++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic stage-boundary pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Bit positions inside the control field {RWSel[1:0], MemtoReg, RegWrite}
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_RWSEL_LO = 2;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NFIELDS = 6;
  localparam int DEF_RD_W    = 5;
  localparam int DEF_CTRL_W  = 4;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/pipe_payload_reg.sv
// Reset-to-zero payload register with load enable; holds one {ctrl, rd, data} entry.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pay_q;
  logic [W-1:0] pay_d;

  always_comb begin
    pay_d = pay_q;
    if (ld) pay_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pay_q <= '0;
    else       pay_q <= pay_d;
  end

  assign q = pay_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// Two-entry elastic pipeline register (main + skid) with flush, bubble-safe
// control outputs and a saturating back-pressure cycle counter.
module mem_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NFIELDS = DEF_NFIELDS,
  parameter int RD_W    = DEF_RD_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [RD_W-1:0]           in_rd,
  input  logic [NFIELDS*DATA_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [RD_W-1:0]           out_rd,
  output logic [NFIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt,
  input  logic                      cnt_clr
);

  localparam int DW    = NFIELDS * DATA_W;
  localparam int PAY_W = CTRL_W + RD_W + DW;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return (v == '1) ? v : v + one;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               accept, pop;
  logic               main_ld, skid_ld;
  logic [PAY_W-1:0]   in_pay, main_d, main_q, skid_q;

  assign in_pay    = {in_ctrl, in_rd, in_data};
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  // Flush swallows a same-cycle accept even though in_ready may read 1
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = in_pay;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr)
      stall_cnt_d = '0;
    else if (out_valid && !out_ready && !flush)
      stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_payload_reg #(.W(PAY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .ld    (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .ld    (skid_ld),
    .d     (in_pay),
    .q     (skid_q)
  );

  // Control is masked on bubbles so RegWrite can never fire on an invalid slot
  assign out_ctrl  = out_valid ? main_q[PAY_W-1 -: CTRL_W] : '0;
  assign out_rd    = main_q[DW +: RD_W];
  assign out_data  = main_q[DW-1:0];
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: directed stimulus pushes expected entries,
// a negedge monitor pops and compares on every downstream transfer.
module tb_mem_wb_pipe_reg;

  localparam int DATA_W  = 32;
  localparam int NFIELDS = 6;
  localparam int RD_W    = 5;
  localparam int CTRL_W  = 4;
  localparam int CNT_W   = 4;
  localparam int DW      = NFIELDS * DATA_W;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic [DW-1:0]     data;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0]   in_rd;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0]   out_rd;
  logic [DW-1:0]     out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic              cnt_clr;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  ent_t exp_e;

  mem_wb_pipe_reg #(
    .DATA_W (DATA_W), .NFIELDS(NFIELDS), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_data(input logic [31:0] f0);
    logic [DW-1:0] d;
    for (int i = 0; i < NFIELDS; i++) d[i*DATA_W +: DATA_W] = f0 + (32'(i) << 28);
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [4:0] r,
                       input logic [31:0] f0);
    in_valid = v;
    in_ctrl  = c;
    in_rd    = r;
    in_data  = mk_data(f0);
  endtask

  // Monitor: compare head on each pop, then record any entry accepted this cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'h0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got data %0h with no expected entry", out_data[31:0]);
        end else begin
          exp_e = sb.pop_front();
          checks++;
          if (out_ctrl !== exp_e.ctrl || out_rd !== exp_e.rd || out_data !== exp_e.data) begin
            errors++;
            $display("FAIL sb_entry: got ctrl=%0h rd=%0h f0=%0h expected ctrl=%0h rd=%0h f0=%0h",
                     out_ctrl, out_rd, out_data[31:0], exp_e.ctrl, exp_e.rd, exp_e.data[31:0]);
          end
        end
      end
      if (in_valid && in_ready && !flush) sb.push_back('{in_ctrl, in_rd, in_data});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, 4'h0, 5'd0, 32'h0);
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready",  64'(in_ready),  64'h1);
    chk("rst_occ",       64'(occupancy), 64'h0);
    chk("rst_data",      64'(|out_data), 64'h0);
    reset = 1'b0;

    // Reset in the middle of a stream with two entries held
    drive(1'b1, 4'h3, 5'd1, 32'h11); step();
    drive(1'b1, 4'h3, 5'd2, 32'h22); step();
    drive(1'b0, 4'h0, 5'd0, 32'h0);
    chk("mid_occ2",  64'(occupancy), 64'h2);
    chk("mid_rdy0",  64'(in_ready),  64'h0);
    #3 reset = 1'b1;
    #1;
    sb.delete();
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_ctrl",  64'(out_ctrl),  64'h0);
    chk("arst_rd",    64'(out_rd),    64'h0);
    chk("arst_data",  64'(|out_data), 64'h0);
    chk("arst_occ",   64'(occupancy), 64'h0);
    chk("arst_rdy",   64'(in_ready),  64'h1);
    chk("arst_cnt",   64'(stall_cnt), 64'h0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_occ", 64'(occupancy), 64'h0);

    // Full-rate streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'(i), 5'(i), 32'(i));
      step();
      chk("stream_f0",  64'(out_data[31:0]), 64'(i));
      chk("stream_occ", 64'(occupancy), 64'h1);
    end
    drive(1'b0, 4'h0, 5'd0, 32'h0);
    step();
    chk("stream_cnt", 64'(stall_cnt), 64'h0);
    chk("stream_end", 64'(occupancy), 64'h0);

    // Back-pressure
    out_ready = 1'b0;
    drive(1'b1, 4'h5, 5'd10, 32'hA); step();
    drive(1'b1, 4'h6, 5'd11, 32'hB); step();
    drive(1'b1, 4'h7, 5'd12, 32'hC); step();
    chk("bp_occ",  64'(occupancy), 64'h2);
    chk("bp_rdy",  64'(in_ready),  64'h0);
    chk("bp_cnt",  64'(stall_cnt), 64'h2);
    chk("bp_head", 64'(out_data[31:0]), 64'hA);
    drive(1'b0, 4'h0, 5'd0, 32'h0);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", 64'(out_data[31:0]), 64'hB);
    step();
    drive(1'b1, 4'h7, 5'd12, 32'hC); step();
    drive(1'b0, 4'hF, 5'd0, 32'h0);  step();
    chk("bp_cnt_final", 64'(stall_cnt), 64'h2);

    // Bubble with control lines driven high
    step();
    chk("bub_valid", 64'(out_valid), 64'h0);
    chk("bub_ctrl",  64'(out_ctrl),  64'h0);

    // Flush in TWO
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 5'd13, 32'hD); step();
    drive(1'b1, 4'h1, 5'd14, 32'hE); step();
    chk("fl_pre_cnt", 64'(stall_cnt), 64'h1);
    drive(1'b1, 4'hF, 5'd15, 32'hF); flush = 1'b1; step(); flush = 1'b0;
    sb.delete();
    chk("fl_occ",   64'(occupancy), 64'h0);
    chk("fl_valid", 64'(out_valid), 64'h0);
    chk("fl_cnt",   64'(stall_cnt), 64'h1);
    // Flush in ONE with an accept that must be discarded
    drive(1'b1, 4'h2, 5'd16, 32'h16); step();
    drive(1'b1, 4'hF, 5'd17, 32'h17); flush = 1'b1; step(); flush = 1'b0;
    sb.delete();
    chk("fl1_occ", 64'(occupancy), 64'h0);
    out_ready = 1'b1;
    drive(1'b1, 4'h9, 5'd18, 32'h18); step();
    chk("fl_next_f0", 64'(out_data[31:0]), 64'h18);
    drive(1'b0, 4'h0, 5'd0, 32'h0); step();

    // Saturation and clear priority
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 4'h4, 5'd19, 32'h19); step();
    drive(1'b0, 4'h0, 5'd0, 32'h0);
    repeat (20) step();
    chk("cnt_sat", 64'(stall_cnt), 64'hF);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("cnt_clr", 64'(stall_cnt), 64'h0);
    step();
    chk("cnt_restart", 64'(stall_cnt), 64'h1);
    out_ready = 1'b1; step(); step();
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
